// File: rtl/rx_time_stamper.sv
// Multi-channel RX stage: overwrites the leading word(s) of matching packets with VITA time or elapsed cycles.
// One register stage per channel (latency 1); s_tready = ~m_tvalid | m_tready, so outputs hold while stalled.
module rx_time_stamper #(
    parameter int         NUM_CHANNELS = 1,
    parameter int         WIDTH        = 32,
    parameter logic [3:0] MATCH_TYPE   = 4'b0010,
    parameter logic [7:0] SR_BASE      = 8'd160
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          set_stb,
    input  logic [7:0]                    set_addr,
    input  logic [31:0]                   set_data,
    input  logic [63:0]                   vita_time,
    input  logic [NUM_CHANNELS*WIDTH-1:0] s_tdata,
    input  logic [NUM_CHANNELS*128-1:0]   s_tuser,
    input  logic [NUM_CHANNELS-1:0]       s_tlast,
    input  logic [NUM_CHANNELS-1:0]       s_tvalid,
    output logic [NUM_CHANNELS-1:0]       s_tready,
    output logic [NUM_CHANNELS*WIDTH-1:0] m_tdata,
    output logic [NUM_CHANNELS*128-1:0]   m_tuser,
    output logic [NUM_CHANNELS-1:0]       m_tlast,
    output logic [NUM_CHANNELS-1:0]       m_tvalid,
    input  logic [NUM_CHANNELS-1:0]       m_tready,
    output logic [63:0]                   elapsed,
    output logic                          armed,
    output logic [NUM_CHANNELS*16-1:0]    stamp_count
);

    localparam logic [7:0] CTRL_ADDR = SR_BASE + 8'(NUM_CHANNELS);

    logic                    ctrl_clear;
    logic [NUM_CHANNELS-1:0] last_acc;
    logic                    unused_bits;

    assign ctrl_clear  = set_stb && (set_addr == CTRL_ADDR) && set_data[0];
    assign unused_bits = ^{set_data[31:2], vita_time};

    // A clear outranks a coincident channel-0 tlast, so armed stays low that cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            elapsed <= '0;
            armed   <= 1'b0;
        end else if (ctrl_clear) begin
            elapsed <= '0;
            armed   <= 1'b0;
        end else begin
            if (armed) begin
                elapsed <= elapsed + 64'd1;
            end
            if (last_acc[0]) begin
                armed <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        localparam logic [7:0] MODE_ADDR = SR_BASE + 8'(i);

        logic [1:0]       mode;
        logic [1:0]       pkt_mode;
        logic             pkt_match;
        logic [1:0]       idx;
        logic             acc;
        logic             first;
        logic             live_match;
        logic [WIDTH-1:0] in_dat;
        logic [127:0]     in_user;
        logic [WIDTH-1:0] hold_hi;
        logic [WIDTH-1:0] stamped;
        logic [WIDTH-1:0] dat_q;
        logic [127:0]     user_q;
        logic             last_q;
        logic             vld_q;
        logic [15:0]      cnt_q;

        assign in_dat     = s_tdata[WIDTH*i +: WIDTH];
        assign in_user    = s_tuser[128*i +: 128];
        assign s_tready[i] = ~vld_q | m_tready[i];
        assign acc        = s_tvalid[i] & s_tready[i];
        assign first      = (idx == 2'd0);
        assign live_match = (in_user[127:124] == MATCH_TYPE);
        assign last_acc[i] = acc & s_tlast[i];

        assign m_tdata[WIDTH*i +: WIDTH] = dat_q;
        assign m_tuser[128*i +: 128]     = user_q;
        assign m_tlast[i]                = last_q;
        assign m_tvalid[i]               = vld_q;
        assign stamp_count[16*i +: 16]   = cnt_q;

        // Only the upper time half is ever replayed, and only when it fits in a second word.
        if (WIDTH < 64) begin : g_hold
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    hold_hi <= '0;
                end else if (acc && first) begin
                    hold_hi <= vita_time[2*WIDTH-1:WIDTH];
                end
            end
        end else begin : g_nohold
            assign hold_hi = '0;
        end

        always_comb begin
            stamped = in_dat;
            if (first && live_match) begin
                case (mode)
                    2'd1, 2'd2: stamped = vita_time[WIDTH-1:0];
                    2'd3:       stamped = elapsed[WIDTH-1:0];
                    default:    stamped = in_dat;
                endcase
            end else if ((idx == 2'd1) && pkt_match && (pkt_mode == 2'd2) && (WIDTH < 64)) begin
                stamped = hold_hi;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                mode <= 2'd0;
            end else if (set_stb && (set_addr == MODE_ADDR)) begin
                mode <= set_data[1:0];
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                dat_q     <= '0;
                user_q    <= '0;
                last_q    <= 1'b0;
                vld_q     <= 1'b0;
                idx       <= 2'd0;
                pkt_mode  <= 2'd0;
                pkt_match <= 1'b0;
                cnt_q     <= '0;
            end else begin
                if (s_tready[i]) begin
                    vld_q <= s_tvalid[i];
                    if (s_tvalid[i]) begin
                        dat_q  <= stamped;
                        user_q <= in_user;
                        last_q <= s_tlast[i];
                    end
                end
                if (acc) begin
                    if (s_tlast[i]) begin
                        idx <= 2'd0;
                    end else if (idx != 2'd2) begin
                        idx <= idx + 2'd1;
                    end
                    if (first) begin
                        pkt_mode  <= mode;
                        pkt_match <= live_match;
                        if (live_match && (mode != 2'd0)) begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_time_stamper.sv
// Bench for rx_time_stamper: directed stamping/elapsed/reset scenarios plus randomized two-channel traffic.
module tb_rx_time_stamper;

    localparam int         NCH  = 2;
    localparam int         W    = 32;
    localparam logic [3:0] MT   = 4'b0010;
    localparam logic [7:0] BASE = 8'd160;
    localparam logic [7:0] CTRL = 8'd162;

    typedef struct packed {
        logic [W-1:0] dat;
        logic [127:0] user;
        logic         last;
    } beat_t;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               set_stb;
    logic [7:0]         set_addr;
    logic [31:0]        set_data;
    logic [63:0]        vita_time;
    logic [NCH*W-1:0]   s_tdata;
    logic [NCH*128-1:0] s_tuser;
    logic [NCH-1:0]     s_tlast;
    logic [NCH-1:0]     s_tvalid;
    logic [NCH-1:0]     s_tready;
    logic [NCH*W-1:0]   m_tdata;
    logic [NCH*128-1:0] m_tuser;
    logic [NCH-1:0]     m_tlast;
    logic [NCH-1:0]     m_tvalid;
    logic [NCH-1:0]     m_tready;
    logic [63:0]        elapsed;
    logic               armed;
    logic [NCH*16-1:0]  stamp_count;

    int checks   = 0;
    int failures = 0;
    int unsigned cyc = 0;

    // Packet-level reference state
    logic [1:0]  model_mode [NCH];
    int          wnum       [NCH];
    logic [1:0]  pmode      [NCH];
    bit          pmatch     [NCH];
    logic [63:0] hold       [NCH];
    int unsigned model_cnt  [NCH];
    beat_t       src_q      [NCH][$];
    beat_t       exp_q      [NCH][$];

    rx_time_stamper #(
        .NUM_CHANNELS(NCH), .WIDTH(W), .MATCH_TYPE(MT), .SR_BASE(BASE)
    ) dut (
        .clk(clk), .reset_n(reset_n), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .vita_time(vita_time), .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tlast(s_tlast),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .m_tdata(m_tdata), .m_tuser(m_tuser),
        .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready), .elapsed(elapsed),
        .armed(armed), .stamp_count(stamp_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1);
    end

    function automatic beat_t cur(input int c);
        beat_t b;
        b.dat  = m_tdata[W*c +: W];
        b.user = m_tuser[128*c +: 128];
        b.last = m_tlast[c];
        return b;
    endfunction

    task automatic model_clear;
        for (int c = 0; c < NCH; c++) begin
            model_mode[c] = 2'd0;
            wnum[c]       = 0;
            pmode[c]      = 2'd0;
            pmatch[c]     = 1'b0;
            hold[c]       = '0;
            model_cnt[c]  = 0;
            src_q[c].delete();
            exp_q[c].delete();
        end
    endtask

    // Expected output for an accepted beat, from its position within the packet.
    task automatic predict(input int ch, input beat_t b, output beat_t e);
        e = b;
        if (wnum[ch] == 0) begin
            pmode[ch]  = model_mode[ch];
            pmatch[ch] = (b.user[127:124] == MT);
            hold[ch]   = vita_time;
            if (pmatch[ch] && pmode[ch] != 2'd0) model_cnt[ch] = (model_cnt[ch] + 1) % 65536;
            if (pmatch[ch] && (pmode[ch] == 2'd1 || pmode[ch] == 2'd2)) e.dat = vita_time[W-1:0];
        end else if (wnum[ch] == 1 && pmatch[ch] && pmode[ch] == 2'd2) begin
            e.dat = hold[ch][2*W-1:W];
        end
        wnum[ch] = b.last ? 0 : wnum[ch] + 1;
    endtask

    task automatic do_reset;
        reset_n   = 1'b0;
        set_stb   = 1'b0;
        set_addr  = '0;
        set_data  = '0;
        s_tvalid  = '0;
        s_tlast   = '0;
        s_tdata   = '0;
        s_tuser   = '0;
        m_tready  = '1;
        model_clear();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic write_set(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        set_stb = 1'b1; set_addr = a; set_data = d;
        @(negedge clk);
        set_stb = 1'b0;
        if (a >= BASE && a < BASE + 8'(NCH)) model_mode[a - BASE] = d[1:0];
    endtask

    // Called at a negedge; presents one beat with m_tready high and returns the next-cycle output word.
    task automatic step_beat(input int ch, input logic [W-1:0] d, input logic [3:0] typ,
                             input logic l, output logic [W-1:0] got);
        beat_t b, e;
        b.dat = d; b.user = {typ, 124'h5A}; b.last = l;
        s_tvalid[ch] = 1'b1; s_tdata[W*ch +: W] = d; s_tuser[128*ch +: 128] = b.user;
        s_tlast[ch] = l; m_tready[ch] = 1'b1;
        #1;
        checks++;
        if (s_tready[ch] !== 1'b1) begin
            failures++; $display("FAIL step_ready ch%0d got=%b exp=1", ch, s_tready[ch]);
        end
        predict(ch, b, e);
        @(negedge clk);
        checks++;
        if (m_tvalid[ch] !== 1'b1) begin
            failures++; $display("FAIL latency1_valid ch%0d got=%b exp=1", ch, m_tvalid[ch]);
        end
        got = m_tdata[W*ch +: W];
        s_tvalid[ch] = 1'b0;
    endtask

    task automatic add_pkt(input int ch, input int len, input logic [3:0] typ);
        beat_t b;
        logic [123:0] u;
        u = {28'($urandom), $urandom, $urandom, $urandom};
        for (int k = 0; k < len; k++) begin
            b.dat = $urandom; b.user = {typ, u}; b.last = (k == len - 1);
            src_q[ch].push_back(b);
        end
    endtask

    task automatic run_traffic(input int vld_pct, input int rdy_pct, input int max_cyc,
                               input bit rnd_vita, output int used);
        beat_t prev [NCH];
        bit    stalled [NCH];
        beat_t e, got, b;
        int    pending;
        used = 0;
        for (int c = 0; c < NCH; c++) stalled[c] = 1'b0;
        while (used < max_cyc) begin
            pending = 0;
            for (int c = 0; c < NCH; c++) pending += src_q[c].size() + exp_q[c].size();
            if (pending == 0) break;
            @(negedge clk);
            used++;
            for (int c = 0; c < NCH; c++) begin
                if (stalled[c]) begin
                    got = cur(c);
                    checks++;
                    if (m_tvalid[c] !== 1'b1 || got !== prev[c]) begin
                        failures++;
                        $display("FAIL stall_hold ch%0d got vld=%b dat=%h exp vld=1 dat=%h",
                                 c, m_tvalid[c], got.dat, prev[c].dat);
                    end
                end
            end
            if (rnd_vita) vita_time = {$urandom, $urandom};
            for (int c = 0; c < NCH; c++) begin
                m_tready[c] = ($urandom_range(99) < rdy_pct);
                if (src_q[c].size() != 0 && $urandom_range(99) < vld_pct) begin
                    b = src_q[c][0];
                    s_tvalid[c] = 1'b1; s_tdata[W*c +: W] = b.dat;
                    s_tuser[128*c +: 128] = b.user; s_tlast[c] = b.last;
                end else begin
                    s_tvalid[c] = 1'b0; s_tdata[W*c +: W] = $urandom;
                    s_tuser[128*c +: 128] = {$urandom, $urandom, $urandom, $urandom};
                    s_tlast[c] = 1'($urandom);
                end
            end
            #1;
            for (int c = 0; c < NCH; c++) begin
                got = cur(c);
                if (m_tvalid[c] && m_tready[c]) begin
                    checks++;
                    if (exp_q[c].size() == 0) begin
                        failures++;
                        $display("FAIL extra_beat ch%0d got dat=%h exp no beat", c, got.dat);
                    end else begin
                        e = exp_q[c].pop_front();
                        if (got !== e) begin
                            failures++;
                            $display("FAIL beat ch%0d got dat=%h last=%b user=%h exp dat=%h last=%b user=%h",
                                     c, got.dat, got.last, got.user, e.dat, e.last, e.user);
                        end
                    end
                end
                stalled[c] = m_tvalid[c] && !m_tready[c];
                prev[c] = got;
                if (s_tvalid[c] && s_tready[c]) begin
                    b = src_q[c].pop_front();
                    predict(c, b, e);
                    exp_q[c].push_back(e);
                end
            end
        end
        pending = 0;
        for (int c = 0; c < NCH; c++) pending += src_q[c].size() + exp_q[c].size();
        checks++;
        if (pending != 0) begin
            failures++; $display("FAIL traffic_timeout got pending=%0d exp 0", pending);
        end
        @(negedge clk);
        s_tvalid = '0; m_tready = '1;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (m_tvalid !== '0) begin failures++; $display("FAIL rst_m_tvalid got=%b exp=0", m_tvalid); end
        checks++; if (m_tdata !== '0) begin failures++; $display("FAIL rst_m_tdata got=%h exp=0", m_tdata); end
        checks++; if (m_tuser !== '0) begin failures++; $display("FAIL rst_m_tuser got=%h exp=0", m_tuser); end
        checks++; if (m_tlast !== '0) begin failures++; $display("FAIL rst_m_tlast got=%b exp=0", m_tlast); end
        checks++; if (elapsed !== '0) begin failures++; $display("FAIL rst_elapsed got=%h exp=0", elapsed); end
        checks++; if (armed !== 1'b0) begin failures++; $display("FAIL rst_armed got=%b exp=0", armed); end
        checks++; if (stamp_count !== '0) begin failures++; $display("FAIL rst_stamp_count got=%h exp=0", stamp_count); end
        checks++; if (s_tready !== '1) begin failures++; $display("FAIL rst_s_tready got=%b exp=11", s_tready); end
    endtask

    task automatic test_mode1;
        logic [W-1:0] d [4];
        logic [W-1:0] g [4];
        do_reset();
        write_set(BASE, 32'd1);
        vita_time = 64'h0000_0001_0000_00AA;
        for (int k = 0; k < 4; k++) d[k] = $urandom;
        for (int k = 0; k < 4; k++) step_beat(0, d[k], MT, (k == 3), g[k]);
        checks++; if (g[0] !== 32'h0000_00AA) begin failures++; $display("FAIL mode1_word0 got=%h exp=000000aa", g[0]); end
        for (int k = 1; k < 4; k++) begin
            checks++;
            if (g[k] !== d[k]) begin failures++; $display("FAIL mode1_word%0d got=%h exp=%h", k, g[k], d[k]); end
        end
        checks++; if (stamp_count[15:0] !== 16'd1) begin failures++; $display("FAIL mode1_count got=%0d exp=1", stamp_count[15:0]); end
        checks++; if (stamp_count[31:16] !== 16'd0) begin failures++; $display("FAIL mode1_count_ch1 got=%0d exp=0", stamp_count[31:16]); end
    endtask

    task automatic test_mode2;
        logic [W-1:0] d [6];
        logic [W-1:0] g [6];
        do_reset();
        write_set(BASE, 32'd2);
        for (int k = 0; k < 6; k++) d[k] = $urandom;
        vita_time = 64'h0000_0001_0000_00AA;
        step_beat(0, d[0], MT, 1'b0, g[0]);
        vita_time = 64'h0000_0002_0000_0000;
        step_beat(0, d[1], MT, 1'b0, g[1]);
        step_beat(0, d[2], MT, 1'b1, g[2]);
        vita_time = 64'h0000_0003_0000_0055;
        step_beat(0, d[3], MT, 1'b1, g[3]);
        step_beat(0, d[4], MT, 1'b0, g[4]);
        step_beat(0, d[5], MT, 1'b1, g[5]);
        checks++; if (g[0] !== 32'h0000_00AA) begin failures++; $display("FAIL mode2_word0 got=%h exp=000000aa", g[0]); end
        checks++; if (g[1] !== 32'h0000_0001) begin failures++; $display("FAIL mode2_word1_held got=%h exp=00000001", g[1]); end
        checks++; if (g[2] !== d[2]) begin failures++; $display("FAIL mode2_word2 got=%h exp=%h", g[2], d[2]); end
        checks++; if (g[3] !== 32'h0000_0055) begin failures++; $display("FAIL mode2_single got=%h exp=00000055", g[3]); end
        checks++; if (g[4] !== 32'h0000_0055) begin failures++; $display("FAIL mode2_after_single_w0 got=%h exp=00000055", g[4]); end
        checks++; if (g[5] !== 32'h0000_0003) begin failures++; $display("FAIL mode2_after_single_w1 got=%h exp=00000003", g[5]); end
        checks++; if (stamp_count[15:0] !== 16'd3) begin failures++; $display("FAIL mode2_count got=%0d exp=3", stamp_count[15:0]); end
    endtask

    task automatic test_match_midmode;
        logic [W-1:0] d [8];
        logic [W-1:0] g [8];
        do_reset();
        write_set(BASE, 32'd1);
        vita_time = 64'h0000_0007_1234_5678;
        for (int k = 0; k < 8; k++) d[k] = $urandom;
        step_beat(0, d[0], 4'b0001, 1'b0, g[0]);
        step_beat(0, d[1], 4'b0001, 1'b0, g[1]);
        step_beat(0, d[2], 4'b0001, 1'b1, g[2]);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (g[k] !== d[k]) begin failures++; $display("FAIL nomatch_word%0d got=%h exp=%h", k, g[k], d[k]); end
        end
        checks++; if (stamp_count[15:0] !== 16'd0) begin failures++; $display("FAIL nomatch_count got=%0d exp=0", stamp_count[15:0]); end
        step_beat(0, d[3], MT, 1'b0, g[3]);
        write_set(BASE, 32'd2);
        step_beat(0, d[4], MT, 1'b0, g[4]);
        step_beat(0, d[5], MT, 1'b1, g[5]);
        step_beat(0, d[6], MT, 1'b0, g[6]);
        step_beat(0, d[7], MT, 1'b1, g[7]);
        checks++; if (g[3] !== 32'h1234_5678) begin failures++; $display("FAIL midmode_word0 got=%h exp=12345678", g[3]); end
        checks++; if (g[4] !== d[4]) begin failures++; $display("FAIL midmode_word1 got=%h exp=%h", g[4], d[4]); end
        checks++; if (g[5] !== d[5]) begin failures++; $display("FAIL midmode_word2 got=%h exp=%h", g[5], d[5]); end
        checks++; if (g[6] !== 32'h1234_5678) begin failures++; $display("FAIL nextpkt_word0 got=%h exp=12345678", g[6]); end
        checks++; if (g[7] !== 32'h0000_0007) begin failures++; $display("FAIL nextpkt_word1 got=%h exp=00000007", g[7]); end
        checks++; if (stamp_count[15:0] !== 16'd2) begin failures++; $display("FAIL midmode_count got=%0d exp=2", stamp_count[15:0]); end
    endtask

    task automatic test_back_to_back;
        int used, n, len;
        do_reset();
        write_set(BASE, 32'd1);
        write_set(BASE + 8'd1, 32'd2);
        for (int c = 0; c < NCH; c++) begin
            n = 0;
            while (n < 20) begin
                len = $urandom_range(1, 5);
                if (n + len > 20) len = 20 - n;
                add_pkt(c, len, MT);
                n += len;
            end
        end
        run_traffic(100, 100, 200, 1'b1, used);
        checks++;
        if (used != 21) begin failures++; $display("FAIL b2b_cycles got=%0d exp=21", used); end
    endtask

    task automatic test_random_stall;
        int used, n, len;
        logic [3:0] typ;
        do_reset();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < NCH; c++) write_set(BASE + 8'(c), 32'($urandom_range(2)));
            for (int c = 0; c < NCH; c++) begin
                n = 0;
                while (n < 50) begin
                    len = $urandom_range(1, 6);
                    if (n + len > 50) len = 50 - n;
                    typ = ($urandom_range(9) < 7) ? MT : 4'($urandom_range(15));
                    add_pkt(c, len, typ);
                    n += len;
                end
            end
            run_traffic(70, 50, 3000, 1'b1, used);
        end
        for (int c = 0; c < NCH; c++) begin
            checks++;
            if (stamp_count[16*c +: 16] !== 16'(model_cnt[c])) begin
                failures++;
                $display("FAIL random_count ch%0d got=%0d exp=%0d", c, stamp_count[16*c +: 16], 16'(model_cnt[c]));
            end
        end
    endtask

    task automatic test_elapsed;
        int unsigned arm;
        int n;
        logic [W-1:0] g, d;
        logic [W-1:0] exp3;
        do_reset();
        write_set(BASE + 8'd1, 32'd3);
        checks++; if (armed !== 1'b0 || elapsed !== 64'd0) begin
            failures++; $display("FAIL elapsed_idle got armed=%b elapsed=%0d exp 0/0", armed, elapsed);
        end
        s_tvalid[0] = 1'b1; s_tlast[0] = 1'b1; s_tuser[127:0] = '0;
        @(negedge clk);
        arm = cyc;
        s_tvalid[0] = 1'b0; s_tlast[0] = 1'b0;
        checks++; if (armed !== 1'b1 || elapsed !== 64'd0) begin
            failures++; $display("FAIL elapsed_arm got armed=%b elapsed=%0d exp 1/0", armed, elapsed);
        end
        repeat (7) @(negedge clk);
        exp3 = W'(cyc - arm);
        d = $urandom;
        step_beat(1, d, MT, 1'b1, g);
        checks++; if (g !== exp3) begin failures++; $display("FAIL mode3_stamp got=%h exp=%h", g, exp3); end
        n = 19 - int'(cyc - arm);
        repeat (n) @(negedge clk);
        checks++; if (elapsed !== 64'd19 || armed !== 1'b1) begin
            failures++; $display("FAIL elapsed_19 got elapsed=%0d armed=%b exp 19/1", elapsed, armed);
        end
        set_stb = 1'b1; set_addr = CTRL; set_data = 32'd1;
        @(negedge clk);
        set_stb = 1'b0;
        checks++; if (elapsed !== 64'd0 || armed !== 1'b0) begin
            failures++; $display("FAIL elapsed_clear got elapsed=%0d armed=%b exp 0/0", elapsed, armed);
        end
        repeat (3) @(negedge clk);
        checks++; if (elapsed !== 64'd0 || armed !== 1'b0) begin
            failures++; $display("FAIL elapsed_stay got elapsed=%0d armed=%b exp 0/0", elapsed, armed);
        end
        s_tvalid[0] = 1'b1; s_tlast[0] = 1'b1;
        set_stb = 1'b1; set_addr = CTRL; set_data = 32'd1;
        @(negedge clk);
        s_tvalid[0] = 1'b0; s_tlast[0] = 1'b0; set_stb = 1'b0;
        checks++; if (armed !== 1'b0) begin failures++; $display("FAIL coincident_armed got=%b exp=0", armed); end
        @(negedge clk);
        checks++; if (armed !== 1'b0 || elapsed !== 64'd0) begin
            failures++; $display("FAIL coincident_after got armed=%b elapsed=%0d exp 0/0", armed, elapsed);
        end
    endtask

    task automatic test_reset_midpacket;
        logic [W-1:0] g, d;
        do_reset();
        write_set(BASE, 32'd1);
        vita_time = 64'h0000_0000_CAFE_0001;
        step_beat(0, $urandom, MT, 1'b0, g);
        step_beat(0, $urandom, MT, 1'b0, g);
        s_tvalid[0] = 1'b1; s_tdata[W-1:0] = $urandom; s_tuser[127:0] = {MT, 124'h5A}; s_tlast[0] = 1'b0;
        #2 reset_n = 1'b0;
        @(negedge clk);
        s_tvalid[0] = 1'b0;
        checks++; if (m_tvalid !== '0 || m_tdata !== '0 || m_tlast !== '0) begin
            failures++; $display("FAIL midrst_outputs got vld=%b dat=%h exp 0", m_tvalid, m_tdata);
        end
        checks++; if (stamp_count !== '0 || elapsed !== '0 || armed !== 1'b0) begin
            failures++; $display("FAIL midrst_counters got cnt=%h elapsed=%h armed=%b exp 0", stamp_count, elapsed, armed);
        end
        checks++; if (s_tready !== '1) begin failures++; $display("FAIL midrst_ready got=%b exp=11", s_tready); end
        model_clear();
        reset_n = 1'b1;
        write_set(BASE, 32'd1);
        d = $urandom;
        step_beat(0, d, MT, 1'b1, g);
        checks++; if (g !== 32'hCAFE_0001) begin failures++; $display("FAIL midrst_word0 got=%h exp=cafe0001", g); end
        checks++; if (stamp_count[15:0] !== 16'd1) begin failures++; $display("FAIL midrst_count got=%0d exp=1", stamp_count[15:0]); end
    endtask

    initial begin
        vita_time = '0;
        test_reset();
        test_mode1();
        test_mode2();
        test_match_midmode();
        test_back_to_back();
        test_random_stall();
        test_elapsed();
        test_reset_midpacket();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_time_stamper.md
Name: rx_time_stamper

Overview:
- Multi-channel AXI-stream stage placed between the radio datapath RX outputs and the per-channel AXI wrappers.
- It overwrites the leading sample(s) of selected RX packets with VITA time or an elapsed-cycle count, replacing ad-hoc single-channel time substitution.
- It is parametrised in channel count, sample width and matched packet type, and gives per-channel runtime mode control over the settings bus.
- All stamping is packet-aligned and registered, with one cycle of latency.

Parameters:
- NUM_CHANNELS, 1, number of independent RX streams.
- WIDTH, 32, sample width in bits; legal values are 16, 32 and 64.
- MATCH_TYPE, 4'b0010, value of tuser[127:124] that marks a packet as eligible for stamping.
- SR_BASE, 8'd160, settings address of channel 0 mode. Channel i mode is at SR_BASE+i. The control register is at SR_BASE+NUM_CHANNELS.

Ports:
- clk, input, 1, single clock for the block.
- reset_n, input, 1, asynchronous active-low reset.
- set_stb, input, 1, settings strobe.
- set_addr, input, 8, settings address.
- set_data, input, 32, settings data.
- vita_time, input, 64, current VITA time.
- s_tdata, input, NUM_CHANNELS*WIDTH, RX samples, channel i at [WIDTH*i +: WIDTH].
- s_tuser, input, NUM_CHANNELS*128, packet header; constant within a packet.
- s_tlast, input, NUM_CHANNELS, end of packet.
- s_tvalid, input, NUM_CHANNELS, input valid.
- s_tready, output, NUM_CHANNELS, input ready.
- m_tdata, output, NUM_CHANNELS*WIDTH, stamped samples.
- m_tuser, output, NUM_CHANNELS*128, tuser delayed with the data.
- m_tlast, output, NUM_CHANNELS, end of packet.
- m_tvalid, output, NUM_CHANNELS, output valid.
- m_tready, input, NUM_CHANNELS, output ready.
- elapsed, output, 64, elapsed-cycle counter.
- armed, output, 1, high while elapsed is counting.
- stamp_count, output, NUM_CHANNELS*16, per-channel count of stamped packets.

Behaviour:
- Reset: while reset_n is low, every register clears.
  - All m_* outputs, elapsed, armed and stamp_count read 0.
  - All channel modes are 0.
  - s_tready reads 1 (follows from m_tvalid = 0).
- Channels are fully independent except for the shared vita_time, elapsed and control register.
- Handshake, per channel: one output register stage.
  - s_tready[i] = ~m_tvalid[i] | m_tready[i].
  - An input beat is accepted when s_tvalid & s_tready; it appears on m_* on the next cycle. Latency is 1.
  - Throughput is 1 beat per cycle under continuous ready.
  - m_* stay stable while m_tvalid & ~m_tready.
- Word index, per channel: a 2-bit counter.
  - It increments on each accepted beat and saturates at 2.
  - It clears to 0 on an accepted beat with tlast.
  - Index 0 marks the first word of a packet.
- Packet latch, on an accepted index-0 beat:
  - pkt_mode <= mode[i].
  - pkt_match <= (s_tuser[127:124] == MATCH_TYPE).
  - time_hold <= vita_time.
  - Mode writes made mid-packet take effect only on the next packet.
- Modes, 2 bits per channel. Stamping applies only when match is true; for the index-0 beat, match and mode use the live values of the same cycle.
  - Mode 0: pass-through.
  - Mode 1: word 0 data = vita_time[WIDTH-1:0].
  - Mode 2: word 0 = vita_time[WIDTH-1:0] and word 1 = time_hold[2*WIDTH-1:WIDTH]. When WIDTH = 64, mode 2 behaves as mode 1.
  - Mode 3: word 0 = elapsed[WIDTH-1:0].
  - Other words pass through unchanged.
- stamp_count[i]:
  - Increments by 1 on each accepted index-0 beat whose match is true and whose mode is non-zero.
  - Wraps from 0xFFFF to 0.
- Elapsed counter:
  - armed sets on the first accepted tlast beat of channel 0.
  - While armed, elapsed increments by 1 every cycle and wraps from 2^64-1 to 0.
  - A write to SR_BASE+NUM_CHANNELS with data bit 0 = 1 clears elapsed to 0 and clears armed.
  - If that clear coincides with a channel-0 tlast, the clear wins and armed stays 0 on that cycle.
- Settings decode:
  - Writes to SR_BASE+i with i < NUM_CHANNELS load mode[i] <= set_data[1:0].
  - Writes to any other address are ignored.
- Boundary cases:
  - A single-word packet in mode 2 stamps only word 0, and the index returns to 0.
  - If s_tvalid drops mid-packet, the index holds.
  - An asynchronous reset mid-packet discards the in-flight beat; the next accepted beat is treated as word 0.

Test Plan:
- Mode 1, WIDTH=32, match type 0010, vita_time = 0x0000_0001_0000_00AA, 4-word packet → m_tdata word 0 = 0x0000_00AA, words 1–3 unchanged, stamp_count = 1.
- Mode 2, same vita_time, vita_time changes to 0x0000_0002_0000_0000 before word 1 → word 1 = 0x0000_0001 (held value); a 1-word packet stamps only its word 0.
- tuser[127:124] = 0001 with mode 1 → data passes unchanged, stamp_count stays 0; a mode write mid-packet affects only the next packet.
- Random m_tready at 50% on 200 beats on each of 2 channels → no beat loss or duplication, m_* stable while stalled, 1-cycle latency when m_tready is held at 1.
- Channel-0 tlast at cycle 10, then a control write of 1 at cycle 30 → elapsed = 19 at cycle 30, then 0 with armed = 0; a coincident tlast and clear leaves armed at 0.
- reset_n asserted low mid-packet on word 2, then released → all outputs are 0, and the next beat is stamped as word 0.
